// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_e    : divider FSM states (IDLE, RUN, DONE)
//   DEF_WIDTH  : default operand width
//   cnt_width  : step-counter width for a given operand width
package div_pkg;

   localparam int DEF_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Counter must hold WIDTH itself (the value after the last increment).
   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

   localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/seq_divider_cla_sub_step.sv
// Trial subtractor for one restoring-division step: diff = a - b in
// WIDTH+1 bits, computed as a + ~b + 1.
//   a, b   : WIDTH+1-bit unsigned operands
//   diff   : WIDTH+1-bit difference
//   borrow : 1 when a < b (inverted carry-out of the MSB)
// The low WIDTH bits use chained 4-bit carry-lookahead slices; the single
// extra top bit is a one-bit extension fed by the last slice's carry.
module cla_sub_step
   import div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH:0] a,
   input  logic [WIDTH:0] b,
   output logic [WIDTH:0] diff,
   output logic           borrow
);

   localparam int NS = WIDTH / 4;

   logic [WIDTH:0] b_inv;
   logic           p_top;
   logic           g_top;
   logic           cout;

   assign b_inv = ~b;

   for (genvar s = 0; s < NS; s++) begin : g_slice
      logic [3:0] g;
      logic [3:0] p;
      logic [3:0] c;
      logic       ci;
      logic       cout;

      // Carry-in of 1 on the first slice completes the two's complement.
      if (s == 0) begin : g_first
         assign ci = 1'b1;
      end else begin : g_chain
         assign ci = g_slice[s-1].cout;
      end

      assign g = a[4*s +: 4] & b_inv[4*s +: 4];
      assign p = a[4*s +: 4] ^ b_inv[4*s +: 4];

      assign c = {
         g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci),
         g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci),
         g[0] | (p[0] & ci),
         ci
      };

      assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0]) | (&p & ci);

      assign diff[4*s +: 4] = p ^ c;
   end

   assign p_top      = a[WIDTH] ^ b_inv[WIDTH];
   assign g_top      = a[WIDTH] & b_inv[WIDTH];
   assign diff[WIDTH] = p_top ^ g_slice[NS-1].cout;
   assign cout       = g_top | (p_top & g_slice[NS-1].cout);
   assign borrow     = ~cout;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   clk, rst_n          : clock, synchronous active-low reset
//   start               : request; sampled only in IDLE
//   dividend, divisor   : operands, latched on an accepted start
//   busy                : high whenever the FSM is not IDLE
//   done                : one-cycle pulse, results valid in that cycle
//   quotient, remainder : results, held until overwritten by the next result
//   div_by_zero         : set with done when the divisor was zero
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] dvsr_q, dvsr_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH:0]   trial_a;
   logic [WIDTH:0]   trial_b;
   logic [WIDTH:0]   trial_diff;
   logic             trial_borrow;
   logic             restore;
   logic [WIDTH-1:0] r_step;
   logic [WIDTH-1:0] q_step;

   // The partial remainder is kept in WIDTH bits: after every step R is
   // below the divisor, so the (WIDTH+1)-th bit of R is always zero.
   assign trial_a = {r_q, q_q[WIDTH-1]};
   assign trial_b = {1'b0, dvsr_q};

   cla_sub_step #(
      .WIDTH (WIDTH)
   ) u_sub (
      .a      (trial_a),
      .b      (trial_b),
      .diff   (trial_diff),
      .borrow (trial_borrow)
   );

   // A difference with its top bit set cannot occur while R < divisor;
   // treating it as a restore keeps the WIDTH-bit R well defined anyway.
   assign restore = trial_borrow | trial_diff[WIDTH];
   assign r_step  = restore ? trial_a[WIDTH-1:0] : trial_diff[WIDTH-1:0];
   assign q_step  = {q_q[WIDTH-2:0], ~restore};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      q_d     = q_q;
      dvsr_d  = dvsr_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               dvsr_d = divisor;
               r_d    = '0;
               q_d    = dividend;
               cnt_d  = '0;
               dbz_d  = 1'b0;
               if (divisor == '0) begin
                  state_d = DONE;
                  quot_d  = '1;
                  rem_d   = dividend;
                  dbz_d   = 1'b1;
                  done_d  = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            r_d   = r_step;
            q_d   = q_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) begin
               state_d = DONE;
               quot_d  = q_step;
               rem_d   = r_step;
               done_d  = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Working registers only matter between accept and DONE, so they carry
   // no reset.
   always_ff @(posedge clk) begin
      r_q    <= r_d;
      q_q    <= q_d;
      dvsr_q <= dvsr_d;
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle unsigned restoring divider for the RISC processor datapath, the inverse companion to the carry-lookahead adder path. It accepts a dividend/divisor pair on a start pulse and produces one quotient bit per clock by trial subtraction. Quotient, remainder and a divide-by-zero flag are returned with a one-cycle `done` pulse. It sits beside the ALU and is used by the control unit for DIV/MOD instructions, which stall on `busy`.

## Interface
- `WIDTH`, default 16: operand width in bits. Must be a multiple of 4 and at least 4.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `start`, input, 1: request a division. Sampled only in IDLE.
- `dividend`, input, WIDTH: numerator, sampled on accepting `start`.
- `divisor`, input, WIDTH: denominator, sampled on accepting `start`.
- `busy`, output, 1: high whenever state is not IDLE.
- `done`, output, 1: one-cycle pulse; results are valid this cycle.
- `quotient`, output, WIDTH: result. Held until the next accepted `start`.
- `remainder`, output, WIDTH: result. Held until the next accepted `start`.
- `div_by_zero`, output, 1: set with `done` when the divisor was 0. Held like the results.

## Operation
- States:
  - IDLE → RUN on `start` with a nonzero divisor.
  - IDLE → DONE on `start` with divisor == 0.
  - RUN → DONE after WIDTH steps.
  - DONE → IDLE unconditionally.
- Accept (IDLE and `start`):
  - Latch the divisor.
  - Partial remainder R (WIDTH+1 bits) := 0.
  - Shift register Q := dividend.
  - Step counter := 0.
  - Clear `div_by_zero`.
- RUN step, one per cycle:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]} − {0, divisor}, computed in WIDTH+1 bits.
  - If there is no borrow (T ≥ 0): R := T and shift 1 into Q's LSB.
  - Otherwise: R := {R[WIDTH-1:0], Q[WIDTH-1]} and shift 0 into Q's LSB.
  - Counter increments. The last step is when counter == WIDTH−1.
- DONE state:
  - `quotient` = Q and `remainder` = R[WIDTH-1:0].
  - `done` = 1 for exactly this cycle.
- Divide-by-zero path:
  - `quotient` = all ones.
  - `remainder` = dividend.
  - `div_by_zero` = 1.
- Ignored inputs:
  - `start` in RUN or DONE is ignored; there is no queuing.
  - `dividend` and `divisor` changing after acceptance have no effect.
- Arithmetic rules:
  - All arithmetic is unsigned.
  - Subtraction is a + ~b + 1, and the borrow is the inverted carry-out of the MSB.
  - Results satisfy dividend = quotient·divisor + remainder, with remainder < divisor.

## Timing
- Reset (rst_n = 0 at an edge):
  - State → IDLE.
  - `busy`, `done` and `div_by_zero` → 0.
  - `quotient` and `remainder` → 0.
  - Counter → 0.
  - Reset mid-RUN aborts with no `done` pulse.
- Normal latency:
  - `start` is accepted at edge k.
  - `busy` is high from edge k.
  - `done` is high in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles of `busy`.
  - `busy` falls at edge k+WIDTH+1.
- Divide-by-zero latency: `done` is high in the cycle after edge k; `busy` is high for 1 cycle.
- Back-to-back: the earliest next accept is at edge k+WIDTH+2, the first edge with state in IDLE. Throughput is 1 result per WIDTH+2 cycles.
- A `start` coincident with reset deassertion is ignored; the reset edge wins.
- Outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Shared package `div_pkg`:
  - state enum (IDLE, RUN, DONE)
  - default `WIDTH` constant
  - step counter width, $clog2(WIDTH)+1
- One sub-module, `cla_sub_step`:
  - (WIDTH+1)-bit trial subtractor built from chained 4-bit carry-lookahead slices.
  - Inverted subtrahend, carry-in 1.
  - Outputs the difference and borrow.
  - Purely combinational; instantiated once.
- The top level holds the FSM, counter, R/Q/divisor registers and the output registers.

## Test plan
- 100 / 7, WIDTH=16: `quotient` 14, `remainder` 2, `div_by_zero` 0. `done` exactly 17 cycles after the accept edge; `busy` high 17 cycles.
- 0xFFFF / 0x0001: `quotient` 0xFFFF, `remainder` 0. Also 3 / 10: `quotient` 0, `remainder` 3.
- 5 / 0: `done` the cycle after accept, `quotient` 0xFFFF, `remainder` 5, `div_by_zero` 1. The next valid division clears `div_by_zero`.
- Ignored requests: 1000 / 3 started, then `start` pulsed with 9 / 9 at cycles 3 and 17. The result is still 333 r 1, with exactly one `done` pulse. A new `start` in the following IDLE cycle is accepted.
- Reset mid-operation: `rst_n` low for one edge at cycle 8 of a division. All outputs are 0 next cycle, with no `done` pulse. A new 50 / 5 then gives 10 r 0 on normal timing.
- Random regression: 10k random pairs, including divisor 1, divisor > dividend and divisor = dividend. Check q·d + r = n and r < d against a reference model.
